hazard_stall_ctrl: RTL and testbench

- Stall/flush generator for the 5-stage RISC-V pipeline. It is the decode-side counterpart of the forwarding path.
- Where forwarding cannot resolve a RAW dependence, this block freezes Fetch/Decode and bubbles Execute:
  - a load result is not ready yet;
  - a multi-cycle divide destination is pending;
  - the divider is structurally busy.
- It redirects the pipeline on taken branches/jumps.
- It owns the divider scoreboard: busy state, latency counter, pending destination register and the writeback strobe.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/div_scoreboard.sv | 71 +++++++
 rtl/hazard_stall_ctrl.sv | 80 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-side hazard/stall controller.
//   div_state_t : divider scoreboard state (IDLE / BUSY / DONE)
//   REG_ZERO    : x0 register index, never a hazard source
//   reg_match() : dst==src compare that ignores x0 destinations
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when src reads a register that dst is about to write; x0 never matches.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/div_scoreboard.sv
// Divider scoreboard: tracks one in-flight multi-cycle divide.
//   clk, rst     : clock, async active-high reset
//   i_start      : divide issue request from Execute
//   i_rd         : destination register of the issuing divide
//   o_state      : IDLE / BUSY / DONE
//   o_div_rd     : destination of the pending/completing divide
//   o_wb_valid   : result presented to Writeback (DONE cycle)
module div_scoreboard
  import hazard_pkg::*;
#(
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [4:0] i_rd,
  output div_state_t o_state,
  output logic [4:0] o_div_rd,
  output logic       o_wb_valid
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_div_rd;
  logic             w_issue;

  // Issue is accepted from IDLE or DONE only; a start while BUSY is dropped.
  assign w_issue = i_start & (r_state != BUSY);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = BUSY;
      BUSY:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = i_start ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latency counter and pending destination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_div_rd <= REG_ZERO;
    end else if (w_issue) begin
      r_cnt    <= CNT_LOAD;
      r_div_rd <= i_rd;
    end else if ((r_state == BUSY) && (r_cnt != '0)) begin
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    o_state    = r_state;
    o_div_rd   = r_div_rd;
    o_wb_valid = (r_state == DONE);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush generator for the 5-stage pipeline (decode side of forwarding).
//   clk, rst                   : clock, async active-high reset
//   Rs1_D, Rs2_D, DivD         : Decode sources and divide flag
//   Rd_E, RegWriteE, ResultSrcE0, DivStartE, PCSrcE : Execute-stage info
//   StallF, StallD, FlushD, FlushE : pipeline control
//   DivBusy, DivWbValid, DivWbRd   : divider scoreboard status
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic       DivD,
  input  logic [4:0] Rd_E,
  input  logic       RegWriteE,
  input  logic       ResultSrcE0,
  input  logic       DivStartE,
  input  logic       PCSrcE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       DivBusy,
  output logic       DivWbValid,
  output logic [4:0] DivWbRd
);

  div_state_t w_state;
  logic [4:0] w_div_rd;
  logic       w_wb_valid;
  logic       w_busy;
  logic       w_lw_stall;
  logic       w_div_raw;
  logic       w_div_struct;
  logic       w_stall;
  logic       w_run;

  div_scoreboard #(
    .DIV_LATENCY (DIV_LATENCY),
    .CNT_W       (CNT_W)
  ) u_div_sb (
    .clk        (clk),
    .rst        (rst),
    .i_start    (DivStartE),
    .i_rd       (Rd_E),
    .o_state    (w_state),
    .o_div_rd   (w_div_rd),
    .o_wb_valid (w_wb_valid)
  );

  assign w_busy = (w_state == BUSY);

  // Load-use: the loaded value only exists after Memory, so forwarding can't cover it.
  assign w_lw_stall   = ResultSrcE0 & RegWriteE &
                        (reg_match(Rd_E, Rs1_D) | reg_match(Rd_E, Rs2_D));
  // Pending divide result; once in DONE the value reaches W and forwarding covers it.
  assign w_div_raw    = w_busy & (reg_match(w_div_rd, Rs1_D) | reg_match(w_div_rd, Rs2_D));
  // Single divider: a second divide waits until the unit leaves BUSY.
  assign w_div_struct = w_busy & DivD;
  assign w_stall      = w_lw_stall | w_div_raw | w_div_struct;

  // Reset gates the inputs-only paths so nothing leaks out while rst is high.
  assign w_run = ~rst;

  always_comb begin
    // A taken branch discards Decode, so it wins over any stall.
    StallF     = w_run & w_stall & ~PCSrcE;
    StallD     = w_run & w_stall & ~PCSrcE;
    FlushD     = w_run & PCSrcE;
    FlushE     = w_run & (w_stall | PCSrcE);
    DivBusy    = w_run & w_busy;
    DivWbValid = w_run & w_wb_valid;
    DivWbRd    = w_run ? w_div_rd : REG_ZERO;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rd_E;
  logic       DivD, RegWriteE, ResultSrcE0, DivStartE, PCSrcE;
  logic       StallF, StallD, FlushD, FlushE, DivBusy, DivWbValid;
  logic [4:0] DivWbRd;

  int n_assert = 0;
  int n_fail   = 0;

  // {StallF, StallD, FlushD, FlushE, DivBusy, DivWbValid, DivWbRd}
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.DIV_LATENCY(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .DivD(DivD),
    .Rd_E(Rd_E), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0),
    .DivStartE(DivStartE), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .DivBusy(DivBusy), .DivWbValid(DivWbValid), .DivWbRd(DivWbRd)
  );

  function automatic logic [10:0] mk(input logic st, input logic fd, input logic fe,
                                     input logic bsy, input logic wbv, input logic [4:0] rd);
    return {st, st, fd, fe, bsy, wbv, rd};
  endfunction

  task automatic push(input logic [10:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    logic [10:0] e;
    logic [10:0] got;
    e   = exp_q.pop_front();
    got = {StallF, StallD, FlushD, FlushE, DivBusy, DivWbValid, DivWbRd};
    n_assert++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, e);
    end
  endtask

  // Push the expectation, then compare at the falling edge of the same cycle.
  task automatic expect_cyc(input string tag, input logic [10:0] e);
    push(e);
    @(negedge clk);
    check(tag);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    Rs1_D = 0; Rs2_D = 0; Rd_E = 0; DivD = 0;
    RegWriteE = 0; ResultSrcE0 = 0; DivStartE = 0; PCSrcE = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Load-use conditions present during reset: outputs must still be zero.
    ResultSrcE0 = 1; RegWriteE = 1; Rd_E = 5; Rs2_D = 5;
    expect_cyc("reset_forced_zero", mk(0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;

    // Load-use
    expect_cyc("lw_rs2", mk(1, 0, 1, 0, 0, 0));
    tick();
    Rd_E = 0; Rs2_D = 0;
    expect_cyc("lw_x0", mk(0, 0, 0, 0, 0, 0));
    tick();
    Rd_E = 5; Rs1_D = 5; Rs2_D = 2;
    expect_cyc("lw_rs1", mk(1, 0, 1, 0, 0, 0));
    tick();
    RegWriteE = 0;
    expect_cyc("lw_nowrite", mk(0, 0, 0, 0, 0, 0));
    tick();

    // Branch priority over load-use
    RegWriteE = 1; PCSrcE = 1;
    expect_cyc("branch_prio", mk(0, 1, 1, 0, 0, 0));
    tick();
    PCSrcE = 0; RegWriteE = 0; ResultSrcE0 = 0;
    expect_cyc("branch_only_off", mk(0, 0, 0, 0, 0, 0));
    tick();

    // Divide RAW: issue rd=7 at cycle 0, Rs1_D=7 held
    idle_inputs();
    DivStartE = 1; Rd_E = 7; Rs1_D = 7;
    expect_cyc("div_issue_c0", mk(0, 0, 0, 0, 0, 0));
    tick();
    DivStartE = 0; Rd_E = 0;
    for (int c = 1; c <= 8; c++) begin
      expect_cyc($sformatf("div_raw_c%0d", c), mk(1, 0, 1, 1, 0, 7));
      tick();
    end
    expect_cyc("div_done_c9", mk(0, 0, 0, 0, 1, 7));
    tick();
    expect_cyc("div_after_c10", mk(0, 0, 0, 0, 0, 7));
    tick();

    // Structural stall, ignored issue while BUSY, back-to-back issue in DONE
    idle_inputs();
    Rs1_D = 1; Rs2_D = 2;
    DivStartE = 1; Rd_E = 3;
    expect_cyc("div2_issue", mk(0, 0, 0, 0, 0, 7));
    tick();
    DivStartE = 0; Rd_E = 0; DivD = 1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin DivStartE = 1; Rd_E = 9; end
      else        begin DivStartE = 0; Rd_E = 0; end
      expect_cyc($sformatf("div_struct_c%0d", c), mk(1, 0, 1, 1, 0, 3));
      tick();
    end
    // DONE: no structural stall, issue the next divide back-to-back
    DivStartE = 1; Rd_E = 12;
    expect_cyc("div2_done", mk(0, 0, 0, 0, 1, 3));
    tick();
    DivStartE = 0; Rd_E = 0; DivD = 0;
    for (int c = 1; c <= 8; c++) begin
      Rs2_D = (c % 2 == 0) ? 5'd12 : 5'd4;
      expect_cyc($sformatf("div3_busy_c%0d", c),
                 (c % 2 == 0) ? mk(1, 0, 1, 1, 0, 12) : mk(0, 0, 0, 1, 0, 12));
      tick();
    end
    expect_cyc("div3_done", mk(0, 0, 0, 0, 1, 12));
    tick();
    expect_cyc("div3_idle", mk(0, 0, 0, 0, 0, 12));
    tick();

    // x0 divide destination never causes a RAW stall
    idle_inputs();
    DivStartE = 1; Rd_E = 0;
    expect_cyc("divx0_issue", mk(0, 0, 0, 0, 0, 12));
    tick();
    DivStartE = 0;
    for (int c = 1; c <= 8; c++) begin
      expect_cyc($sformatf("divx0_c%0d", c), mk(0, 0, 0, 1, 0, 0));
      tick();
    end
    expect_cyc("divx0_done", mk(0, 0, 0, 0, 1, 0));
    tick();

    // Reset mid-divide in BUSY cycle 3
    idle_inputs();
    DivStartE = 1; Rd_E = 15; Rs2_D = 15;
    expect_cyc("rstdiv_issue", mk(0, 0, 0, 0, 0, 0));
    tick();
    DivStartE = 0; Rd_E = 0;
    for (int c = 1; c <= 3; c++) begin
      expect_cyc($sformatf("rstdiv_c%0d", c), mk(1, 0, 1, 1, 0, 15));
      if (c < 3) tick();
    end
    #2;
    rst = 1'b1;
    #1;
    push(mk(0, 0, 0, 0, 0, 0));
    check("rst_async_zero");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      expect_cyc($sformatf("post_rst_c%0d", c), mk(0, 0, 0, 0, 0, 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
